// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
// Definitions shared by the SPI initiator and the matching SPI target:
//   - spi_state_e : frame sequencer states, 3-bit encoding
//   - SCK_IDLE    : level of sck while no frame is running
//   - MSB_FIRST   : shift direction of the serial word
// No ports (package).
// -----------------------------------------------------------------------------
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // waiting for start
    ST_SETUP = 3'd1,  // scs high, first data bit settling before the first rise
    ST_HIGH  = 3'd2,  // sck high phase
    ST_LOW   = 3'd3,  // sck low phase, sdo updated at its start
    ST_GAP   = 3'd4   // scs low, busy still high, guard time before next frame
  } spi_state_e;

  // sck rests low between frames; the active level is its complement.
  localparam logic SCK_IDLE = 1'b0;

  // Word is transmitted and received most-significant bit first.
  localparam bit MSB_FIRST = 1'b1;

endpackage : spi_master_pkg

// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if
// Bundles the local controller handshake and the SPI pins of one initiator.
// Parameter:
//   size : frame length in bits
// Signals:
//   sck, sdo, scs : serial clock, serial data out, serial select (initiator drives)
//   sdi           : serial data in from the target
//   pdi, start    : word to send and frame request (controller drives)
//   pdo, busy, done : received word, frame in progress, one-cycle completion pulse
// Modports:
//   master : the initiator side (spi_master)
//   slave  : the environment side (controller plus serial target)
// -----------------------------------------------------------------------------
interface spi_master_if #(
  parameter int size = 8
);

  logic            sck;
  logic            sdo;
  logic            sdi;
  logic            scs;
  logic [size-1:0] pdi;
  logic [size-1:0] pdo;
  logic            start;
  logic            busy;
  logic            done;

  modport master (
    output sck, sdo, scs, pdo, busy, done,
    input  sdi, pdi, start
  );

  modport slave (
    input  sck, sdo, scs, pdo, busy, done,
    output sdi, pdi, start
  );

endinterface : spi_master_if

// File: rtl/spi_tick.sv
// -----------------------------------------------------------------------------
// spi_tick
// Phase timer for the SPI initiator: while en is high, tick is asserted for one
// cycle every div cycles (on the div-th cycle after en rises). While en is low
// the count is held at zero so every enabled run starts from a full phase.
// Parameter:
//   div  : phase length in clk cycles (>= 2)
// Ports:
//   clk  : reference clock
//   rst  : synchronous reset, active-high
//   en   : count enable
//   tick : one-cycle strobe marking the last cycle of a phase
// -----------------------------------------------------------------------------
module spi_tick #(
  parameter int div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(div);
  localparam logic [CW-1:0] LAST = CW'(div - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : spi_tick

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI initiator clocked by clk. One start request produces one full-duplex
// frame of size bits: scs active-high, sck idle low, MSB first, the target
// samples on sck rising and changes data on sck falling. The initiator samples
// sdi on the clk edge that raises sck, and updates sdo on the edge that lowers
// it, so sdo is stable for a full phase (div cycles) before every rising edge.
//
// Frame timeline, E0 = clk edge that accepts start:
//   E0                    : scs=1, busy=1, sdo=pdi MSB, enter SETUP
//   E0+div                : first sck rise
//   E0+div+2*size*div     : scs=0, pdo updated, done pulse, enter GAP
//   E0+2*div+2*size*div   : busy=0, back to IDLE
//
// Parameters:
//   size : frame length in bits (>= 2)
//   div  : length of each sck phase in clk cycles (>= 4)
// Ports:
//   clk  : reference clock
//   rst  : synchronous reset, active-high
//   bus  : spi_master_if.master (sck, sdo, sdi, scs, pdi, pdo, start, busy, done)
// -----------------------------------------------------------------------------
module spi_master
  import spi_master_pkg::*;
#(
  parameter int size = 8,
  parameter int div  = 4
) (
  input  logic          clk,
  input  logic          rst,
  spi_master_if.master  bus
);

  localparam int             BCW     = $clog2(size);
  localparam logic [BCW-1:0] BC_LAST = BCW'(size - 1);

  if (size < 2) begin : g_size_chk
    $error("spi_master: size must be at least 2");
  end
  if (div < 4) begin : g_div_chk
    $error("spi_master: div must be at least 4");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_state_e      state_q, state_d;
  logic [size-1:0] xrg_q,   xrg_d;    // shift register, tx out at the top, rx in at the bottom
  logic [BCW-1:0]  bc_q,    bc_d;     // index of the bit currently on the wire
  logic            sck_q,   sck_d;
  logic            sdo_q,   sdo_d;
  logic            scs_q,   scs_d;
  logic [size-1:0] pdo_q,   pdo_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  logic            phase_en;
  logic            phase_tick;
  logic [size-1:0] xrg_shift;

  // ---------------------------------------------------------------------------
  // Phase timer: runs in every state except IDLE, so the first tick after an
  // accepted start lands exactly div cycles later.
  // ---------------------------------------------------------------------------
  assign phase_en = (state_q != ST_IDLE);

  spi_tick #(
    .div (div)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (phase_en),
    .tick (phase_tick)
  );

  // Bit that leaves the shift register next.
  function automatic logic lead_bit(input logic [size-1:0] w);
    return MSB_FIRST ? w[size-1] : w[0];
  endfunction

  // Register contents after one rising-edge shift: the outgoing bit drops off
  // the lead end and the sampled sdi enters the opposite end, so after size
  // shifts the register holds exactly the received word.
  assign xrg_shift = MSB_FIRST ? {xrg_q[size-2:0], bus.sdi}
                               : {bus.sdi, xrg_q[size-1:1]};

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that paths which
    // do not assign it hold the register value instead of inferring a latch.
    state_d = state_q;
    xrg_d   = xrg_q;
    bc_d    = bc_q;
    sck_d   = sck_q;
    sdo_d   = sdo_q;
    scs_d   = scs_q;
    pdo_d   = pdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          xrg_d   = bus.pdi;
          sdo_d   = lead_bit(bus.pdi);
          scs_d   = 1'b1;
          busy_d  = 1'b1;
          bc_d    = '0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (phase_tick) begin
          sck_d   = ~SCK_IDLE;
          xrg_d   = xrg_shift;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        // Falling edge: present the bit that the previous shift moved to the
        // lead position; it then has a whole low phase to settle.
        if (phase_tick) begin
          sck_d   = SCK_IDLE;
          sdo_d   = lead_bit(xrg_q);
          state_d = ST_LOW;
        end
      end

      ST_LOW: begin
        if (phase_tick) begin
          if (bc_q != BC_LAST) begin
            bc_d    = bc_q + BCW'(1);
            sck_d   = ~SCK_IDLE;
            xrg_d   = xrg_shift;
            state_d = ST_HIGH;
          end else begin
            scs_d   = 1'b0;
            pdo_d   = xrg_q;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end
        end
      end

      ST_GAP: begin
        // busy stays high for one more phase so a back-to-back start cannot
        // re-raise scs before the target has seen it low.
        if (phase_tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    if (rst) begin
      state_q <= ST_IDLE;
      xrg_q   <= '0;
      bc_q    <= '0;
      sck_q   <= SCK_IDLE;
      sdo_q   <= 1'b0;
      scs_q   <= 1'b0;
      pdo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xrg_q   <= xrg_d;
      bc_q    <= bc_d;
      sck_q   <= sck_d;
      sdo_q   <= sdo_d;
      scs_q   <= scs_d;
      pdo_q   <= pdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sck  = sck_q;
  assign bus.sdo  = sdo_q;
  assign bus.scs  = scs_q;
  assign bus.pdo  = pdo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : spi_master

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master. Two instances: an 8-bit / div 4 one (looped
// back or wired to a small serial target model) and a 16-bit / div 6 one
// (looped back). Cycle numbers n below count clk edges after the accept edge
// E0; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_spi_master;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_master_if #(.size(8))  b8 ();
  spi_master_if #(.size(16)) b16 ();

  spi_master #(.size(8),  .div(4)) dut8  (.clk(clk), .rst(rst), .bus(b8.master));
  spi_master #(.size(16), .div(6)) dut16 (.clk(clk), .rst(rst), .bus(b16.master));

  // ---------------------------------------------------------------------------
  // Serial target model (8-bit): loads its word when scs rises, shifts its
  // output on sck falling and captures the initiator's sdo on sck rising. It
  // works from clk-registered copies of scs/sck, like a target in this domain.
  // ---------------------------------------------------------------------------
  logic       lb8 = 1'b1;
  logic [7:0] slave_pdi = 8'h00;
  logic       s_scs_q = 1'b0;
  logic       s_sck_q = 1'b0;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;

  always @(posedge clk) begin
    s_scs_q <= b8.scs;
    s_sck_q <= b8.sck;
    if (b8.scs && !s_scs_q)                  s_tx <= slave_pdi;
    else if (b8.scs && !b8.sck && s_sck_q)   s_tx <= {s_tx[6:0], 1'b0};
    if (b8.scs && b8.sck && !s_sck_q)        s_rx <= {s_rx[6:0], b8.sdo};
  end

  assign b8.sdi  = lb8 ? b8.sdo : s_tx[7];
  assign b16.sdi = b16.sdo;

  int total = 0;
  int bad   = 0;

  // Frame measurements filled in by frame8().
  int         m_scs_hi, m_rises, m_done_n, m_done_at, m_busy_fall;
  logic       m_scs_e0, m_busy_e0;
  logic [7:0] m_pdo;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // Run one 8-bit frame from an idle DUT, optionally re-pulsing start on the
  // edges E[re1] and E[re2]. Returns when busy falls or after 150 cycles.
  task automatic frame8(input logic [7:0] word, input int re1, input int re2);
    logic prev_sck;
    int   n;
    b8.pdi   = word;
    b8.start = 1'b1;
    tick_clk();
    b8.start    = 1'b0;
    m_scs_e0    = b8.scs;
    m_busy_e0   = b8.busy;
    m_scs_hi    = 0;
    m_rises     = 0;
    m_done_n    = 0;
    m_done_at   = -1;
    m_busy_fall = -1;
    m_pdo       = 8'h00;
    prev_sck    = 1'b0;
    n           = 0;
    while (m_busy_fall < 0 && n <= 150) begin
      if (b8.scs) m_scs_hi++;
      if (b8.sck && !prev_sck) m_rises++;
      prev_sck = b8.sck;
      if (b8.done) begin
        m_done_n++;
        m_done_at = n;
        m_pdo     = b8.pdo;
      end
      if (!b8.busy) begin
        m_busy_fall = n;
      end else begin
        b8.start = ((n + 1) == re1) || ((n + 1) == re2);
        tick_clk();
        n++;
      end
    end
    b8.start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst       = 1'b1;
    b8.start  = 1'b0;
    b8.pdi    = 8'h00;
    b16.start = 1'b0;
    b16.pdi   = 16'h0000;
    repeat (3) tick_clk();
    total++; if (b8.sck  !== 1'b0)  begin bad++; $display("FAIL reset_sck: got %b want 0", b8.sck); end
    total++; if (b8.sdo  !== 1'b0)  begin bad++; $display("FAIL reset_sdo: got %b want 0", b8.sdo); end
    total++; if (b8.scs  !== 1'b0)  begin bad++; $display("FAIL reset_scs: got %b want 0", b8.scs); end
    total++; if (b8.pdo  !== 8'h00) begin bad++; $display("FAIL reset_pdo: got %h want 00", b8.pdo); end
    total++; if (b8.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", b8.busy); end
    total++; if (b8.done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", b8.done); end
    total++; if ({b16.scs, b16.sck, b16.busy, b16.pdo} !== 19'h0)
      begin bad++; $display("FAIL reset_dut16: got scs=%b sck=%b busy=%b pdo=%h want all 0", b16.scs, b16.sck, b16.busy, b16.pdo); end
    rst = 1'b0;
    tick_clk();
  endtask

  task automatic test_loopback();
    lb8 = 1'b1;
    frame8(8'hA5, -1, -1);
    total++; if ({m_scs_e0, m_busy_e0} !== 2'b11) begin bad++; $display("FAIL loop_e0: got scs=%b busy=%b want 1 1", m_scs_e0, m_busy_e0); end
    total++; if (m_scs_hi    !== 68)    begin bad++; $display("FAIL loop_scs_high: got %0d want 68", m_scs_hi); end
    total++; if (m_rises     !== 8)     begin bad++; $display("FAIL loop_rises: got %0d want 8", m_rises); end
    total++; if (m_done_at   !== 68)    begin bad++; $display("FAIL loop_done_at: got %0d want 68", m_done_at); end
    total++; if (m_done_n    !== 1)     begin bad++; $display("FAIL loop_done_count: got %0d want 1", m_done_n); end
    total++; if (m_pdo       !== 8'hA5) begin bad++; $display("FAIL loop_pdo: got %h want a5", m_pdo); end
    total++; if (m_busy_fall !== 72)    begin bad++; $display("FAIL loop_busy_fall: got %0d want 72", m_busy_fall); end
    tick_clk();
    total++; if (b8.pdo !== 8'hA5) begin bad++; $display("FAIL loop_pdo_hold: got %h want a5", b8.pdo); end
  endtask

  task automatic test_slave();
    lb8       = 1'b0;
    slave_pdi = 8'h3C;
    frame8(8'hC3, -1, -1);
    total++; if (m_pdo !== 8'h3C) begin bad++; $display("FAIL slave_master_pdo: got %h want 3c", m_pdo); end
    total++; if (s_rx  !== 8'hC3) begin bad++; $display("FAIL slave_slave_pdo: got %h want c3", s_rx); end
    lb8 = 1'b1;
    tick_clk();
  endtask

  task automatic test_restart_ignored();
    lb8 = 1'b1;
    frame8(8'h96, 10, 40);
    total++; if (m_done_n    !== 1)     begin bad++; $display("FAIL restart_done_count: got %0d want 1", m_done_n); end
    total++; if (m_rises     !== 8)     begin bad++; $display("FAIL restart_rises: got %0d want 8", m_rises); end
    total++; if (m_scs_hi    !== 68)    begin bad++; $display("FAIL restart_scs_high: got %0d want 68", m_scs_hi); end
    total++; if (m_done_at   !== 68)    begin bad++; $display("FAIL restart_done_at: got %0d want 68", m_done_at); end
    total++; if (m_pdo       !== 8'h96) begin bad++; $display("FAIL restart_pdo: got %h want 96", m_pdo); end
    total++; if (m_busy_fall !== 72)    begin bad++; $display("FAIL restart_busy_fall: got %0d want 72", m_busy_fall); end
    tick_clk();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [3];
    int         dat [3];
    int         lows[2];
    int         n, dones, accepts, low_run;
    logic       prev_scs;
    lb8 = 1'b1;
    for (int i = 0; i < 3; i++) begin got[i] = 8'h00; dat[i] = -1; end
    lows[0] = -1; lows[1] = -1;
    b8.pdi   = 8'h01;
    b8.start = 1'b1;
    tick_clk();
    b8.pdi   = 8'h80;
    accepts  = 1;
    dones    = 0;
    low_run  = 0;
    prev_scs = b8.scs;
    n        = 0;
    while ((dones < 3 || b8.busy) && n < 400) begin
      tick_clk();
      n++;
      if (b8.scs && !prev_scs) begin
        accepts++;
        if (accepts <= 3) lows[accepts-2] = low_run;
        low_run = 0;
        if (accepts == 2) b8.pdi   = 8'hFF;
        if (accepts == 3) b8.start = 1'b0;
      end
      if (!b8.scs) low_run++;
      prev_scs = b8.scs;
      if (b8.done) begin
        if (dones < 3) begin got[dones] = b8.pdo; dat[dones] = n; end
        dones++;
      end
    end
    b8.start = 1'b0;
    total++; if (dones   !== 3)     begin bad++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
    total++; if (accepts !== 3)     begin bad++; $display("FAIL b2b_frames: got %0d want 3", accepts); end
    total++; if (got[0]  !== 8'h01) begin bad++; $display("FAIL b2b_pdo0: got %h want 01", got[0]); end
    total++; if (got[1]  !== 8'h80) begin bad++; $display("FAIL b2b_pdo1: got %h want 80", got[1]); end
    total++; if (got[2]  !== 8'hFF) begin bad++; $display("FAIL b2b_pdo2: got %h want ff", got[2]); end
    total++; if (lows[0] !== 5)     begin bad++; $display("FAIL b2b_gap0: got %0d want 5", lows[0]); end
    total++; if (lows[1] !== 5)     begin bad++; $display("FAIL b2b_gap1: got %0d want 5", lows[1]); end
    total++; if (dat[0]  !== 68)    begin bad++; $display("FAIL b2b_done0_at: got %0d want 68", dat[0]); end
    total++; if (dat[1] - dat[0] !== 73) begin bad++; $display("FAIL b2b_interval0: got %0d want 73", dat[1] - dat[0]); end
    total++; if (dat[2] - dat[1] !== 73) begin bad++; $display("FAIL b2b_interval1: got %0d want 73", dat[2] - dat[1]); end
    tick_clk();
  endtask

  task automatic test_mid_reset();
    int         n;
    logic [7:0] pdo_seen;
    logic       seen;
    lb8      = 1'b1;
    b8.pdi   = 8'hC3;
    b8.start = 1'b1;
    tick_clk();              // after E0
    b8.start = 1'b0;
    repeat (20) tick_clk();  // after E20
    total++; if (b8.sck !== 1'b1) begin bad++; $display("FAIL midrst_pre_sck: got %b want 1", b8.sck); end
    rst = 1'b1;
    tick_clk();              // after E21
    rst = 1'b0;
    total++; if (b8.scs  !== 1'b0)  begin bad++; $display("FAIL midrst_scs: got %b want 0", b8.scs); end
    total++; if (b8.sck  !== 1'b0)  begin bad++; $display("FAIL midrst_sck: got %b want 0", b8.sck); end
    total++; if (b8.busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy: got %b want 0", b8.busy); end
    total++; if (b8.pdo  !== 8'h00) begin bad++; $display("FAIL midrst_pdo: got %h want 00", b8.pdo); end
    tick_clk();              // E22
    tick_clk();              // E23
    tick_clk();              // E24
    b8.pdi   = 8'h5A;
    b8.start = 1'b1;
    tick_clk();              // E25, accepted
    b8.start = 1'b0;
    total++; if ({b8.scs, b8.busy} !== 2'b11) begin bad++; $display("FAIL midrst_restart: got scs=%b busy=%b want 1 1", b8.scs, b8.busy); end
    seen     = 1'b0;
    pdo_seen = 8'h00;
    n        = 0;
    while (b8.busy && n < 150) begin
      tick_clk();
      n++;
      if (b8.done) begin seen = 1'b1; pdo_seen = b8.pdo; end
    end
    total++; if (seen     !== 1'b1)  begin bad++; $display("FAIL midrst_done: got %b want 1", seen); end
    total++; if (pdo_seen !== 8'h5A) begin bad++; $display("FAIL midrst_pdo_after: got %h want 5a", pdo_seen); end
    tick_clk();
  endtask

  task automatic test_size16();
    int          n, scs_hi, rises, done_at, busy_fall, age, min_age;
    logic        prev_sck, prev_sdo;
    logic [15:0] pdo_seen;
    b16.pdi   = 16'h8001;
    b16.start = 1'b1;
    tick_clk();
    b16.start = 1'b0;
    scs_hi    = 0;
    rises     = 0;
    done_at   = -1;
    busy_fall = -1;
    pdo_seen  = 16'h0000;
    prev_sck  = 1'b0;
    prev_sdo  = b16.sdo;
    age       = 0;
    min_age   = 1000;
    n         = 0;
    while (busy_fall < 0 && n <= 300) begin
      if (n > 0) begin
        if (b16.sdo !== prev_sdo) age = 0;
        else                      age++;
      end
      prev_sdo = b16.sdo;
      if (b16.scs) scs_hi++;
      if (b16.sck && !prev_sck) begin
        rises++;
        if (age < min_age) min_age = age;
      end
      prev_sck = b16.sck;
      if (b16.done) begin done_at = n; pdo_seen = b16.pdo; end
      if (!b16.busy) begin
        busy_fall = n;
      end else begin
        tick_clk();
        n++;
      end
    end
    total++; if (rises     !== 16)       begin bad++; $display("FAIL s16_rises: got %0d want 16", rises); end
    total++; if (scs_hi    !== 198)      begin bad++; $display("FAIL s16_scs_high: got %0d want 198", scs_hi); end
    total++; if (pdo_seen  !== 16'h8001) begin bad++; $display("FAIL s16_pdo: got %h want 8001", pdo_seen); end
    total++; if (done_at   !== 198)      begin bad++; $display("FAIL s16_done_at: got %0d want 198", done_at); end
    total++; if (busy_fall !== 204)      begin bad++; $display("FAIL s16_busy_fall: got %0d want 204", busy_fall); end
    total++; if (min_age < 6)            begin bad++; $display("FAIL s16_sdo_setup: got %0d want >=6", min_age); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_restart_ignored();
    test_back_to_back();
    test_mid_reset();
    test_size16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_spi_master
